// File: rtl/rstack_pkg.sv
// Shared definitions for the J1 return stack: delta encodings, default sizes
// and the dump sequencer state type.
package rstack_pkg;

    localparam int RS_DW = 16;
    localparam int RS_AW = 8;

    localparam logic [1:0] RS_NOP  = 2'b00;
    localparam logic [1:0] RS_PUSH = 2'b01;
    localparam logic [1:0] RS_POP  = 2'b11;
    localparam logic [1:0] RS_RSV  = 2'b10;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } dump_state_e;

endpackage

// File: rtl/rstack_dump_fsm.sv
// Valid/ready sequencer that walks the live return-stack entries from the top
// (index rsp) down to index 1, holding each beat until the sink accepts it.
module rstack_dump_fsm
    import rstack_pkg::*;
#(
    parameter int DW = RS_DW,
    parameter int AW = RS_AW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [AW-1:0] rsp,
    input  logic [DW-1:0] rd_data,
    input  logic          dump_req,
    input  logic          dump_ready,
    output logic          dump_valid,
    output logic [DW-1:0] dump_data,
    output logic [AW-1:0] dump_idx,
    output logic          dump_last,
    output logic          stall
);

    dump_state_e state;

    // An empty stack has nothing to stream, so the request is simply ignored.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            dump_idx <= '0;
        end else if (state == IDLE) begin
            if (dump_req && (rsp != '0)) begin
                state    <= SEND;
                dump_idx <= rsp;
            end
        end else if (dump_ready) begin
            if (dump_idx == AW'(1)) begin
                state <= IDLE;
            end else begin
                dump_idx <= dump_idx - AW'(1);
            end
        end
    end

    assign dump_valid = (state == SEND);
    assign stall      = (state == SEND);
    assign dump_last  = (state == SEND) && (dump_idx == AW'(1));
    assign dump_data  = rd_data;

endmodule

// File: rtl/return_stack_reader.sv
// J1 return stack: storage, saturating pointer, registered top-of-stack,
// sticky error flags, and a debug dump port driven by rstack_dump_fsm.
module return_stack_reader
    import rstack_pkg::*;
#(
    parameter int DW = RS_DW,
    parameter int AW = RS_AW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic [1:0]    rs_delta,
    input  logic [DW-1:0] push_data,
    output logic [DW-1:0] r_out,
    output logic [AW-1:0] rsp,
    output logic          empty,
    output logic          full,
    output logic          ovf,
    output logic          unf,
    output logic          ill,
    input  logic          err_clr,
    output logic          stall,
    input  logic          dump_req,
    output logic          dump_valid,
    input  logic          dump_ready,
    output logic [DW-1:0] dump_data,
    output logic [AW-1:0] dump_idx,
    output logic          dump_last
);

    localparam int DEPTH = 1 << AW;

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] rsp_inc;
    logic [AW-1:0] rsp_dec;
    logic          op_ok;
    logic          do_push;
    logic          do_pop;
    logic          set_ovf;
    logic          set_unf;
    logic          set_ill;

    assign empty   = (rsp == '0);
    assign full    = (rsp == '1);
    assign rsp_inc = rsp + AW'(1);
    assign rsp_dec = rsp - AW'(1);

    // Ops presented while the dump engine owns the stack are dropped silently.
    assign op_ok   = en && !stall;
    assign do_push = op_ok && (rs_delta == RS_PUSH) && !full;
    assign do_pop  = op_ok && (rs_delta == RS_POP) && !empty;
    assign set_ovf = op_ok && (rs_delta == RS_PUSH) && full;
    assign set_unf = op_ok && (rs_delta == RS_POP) && empty;
    assign set_ill = op_ok && (rs_delta == RS_RSV);

    // Entry 0 is never written, so it reads back as the empty-stack value 0.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (do_push) begin
            mem[rsp_inc] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rsp   <= '0;
            r_out <= '0;
        end else if (do_push) begin
            rsp   <= rsp_inc;
            r_out <= push_data;
        end else if (do_pop) begin
            rsp   <= rsp_dec;
            r_out <= mem[rsp_dec];
        end
    end

    // A new error in the same cycle as err_clr must not be lost.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ovf <= 1'b0;
            unf <= 1'b0;
            ill <= 1'b0;
        end else begin
            ovf <= set_ovf | (ovf & ~err_clr);
            unf <= set_unf | (unf & ~err_clr);
            ill <= set_ill | (ill & ~err_clr);
        end
    end

    rstack_dump_fsm #(
        .DW(DW),
        .AW(AW)
    ) u_dump (
        .clk       (clk),
        .rst_n     (rst_n),
        .rsp       (rsp),
        .rd_data   (mem[dump_idx]),
        .dump_req  (dump_req),
        .dump_ready(dump_ready),
        .dump_valid(dump_valid),
        .dump_data (dump_data),
        .dump_idx  (dump_idx),
        .dump_last (dump_last),
        .stall     (stall)
    );

endmodule

// File: tb/tb_return_stack_reader.sv
// Self-checking bench for return_stack_reader: directed scenarios plus a
// randomized phase, all checked against a queue-based stack model.
module tb_return_stack_reader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic [1:0]  rs_delta;
    logic [15:0] push_data;
    logic [15:0] r_out;
    logic [7:0]  rsp;
    logic        empty;
    logic        full;
    logic        ovf;
    logic        unf;
    logic        ill;
    logic        err_clr;
    logic        stall;
    logic        dump_req;
    logic        dump_valid;
    logic        dump_ready;
    logic [15:0] dump_data;
    logic [7:0]  dump_idx;
    logic        dump_last;

    int vectors = 0;
    int miscompares = 0;

    logic [15:0] q[$];
    logic        m_ovf;
    logic        m_unf;
    logic        m_ill;
    logic        m_dumping;
    int          m_idx;

    always #5 clk = ~clk;

    return_stack_reader dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .rs_delta  (rs_delta),
        .push_data (push_data),
        .r_out     (r_out),
        .rsp       (rsp),
        .empty     (empty),
        .full      (full),
        .ovf       (ovf),
        .unf       (unf),
        .ill       (ill),
        .err_clr   (err_clr),
        .stall     (stall),
        .dump_req  (dump_req),
        .dump_valid(dump_valid),
        .dump_ready(dump_ready),
        .dump_data (dump_data),
        .dump_idx  (dump_idx),
        .dump_last (dump_last)
    );

    task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drives one cycle of inputs, clocks it, then advances the reference stack.
    task automatic applyStimulus(input logic a_en, input logic [1:0] a_delta,
                                 input logic [15:0] a_data, input logic a_clr,
                                 input logic a_dreq, input logic a_dready,
                                 input logic a_rstn);
        logic was_idle;
        logic s_ovf, s_unf, s_ill;
        rst_n      = a_rstn;
        en         = a_en;
        rs_delta   = a_delta;
        push_data  = a_data;
        err_clr    = a_clr;
        dump_req   = a_dreq;
        dump_ready = a_dready;
        @(posedge clk);
        s_ovf = 1'b0;
        s_unf = 1'b0;
        s_ill = 1'b0;
        if (!a_rstn) begin
            q.delete();
            m_ovf     = 1'b0;
            m_unf     = 1'b0;
            m_ill     = 1'b0;
            m_dumping = 1'b0;
            m_idx     = 0;
        end else begin
            was_idle = !m_dumping;
            if (m_dumping) begin
                if (a_dready) begin
                    if (m_idx == 1) m_dumping = 1'b0;
                    else m_idx = m_idx - 1;
                end
            end else if (a_dreq && q.size() != 0) begin
                m_dumping = 1'b1;
                m_idx     = q.size();
            end
            if (was_idle && a_en) begin
                if (a_delta == 2'b01) begin
                    if (q.size() < 255) q.push_back(a_data);
                    else s_ovf = 1'b1;
                end else if (a_delta == 2'b11) begin
                    if (q.size() > 0) void'(q.pop_back());
                    else s_unf = 1'b1;
                end else if (a_delta == 2'b10) begin
                    s_ill = 1'b1;
                end
            end
            m_ovf = s_ovf | (m_ovf & ~a_clr);
            m_unf = s_unf | (m_unf & ~a_clr);
            m_ill = s_ill | (m_ill & ~a_clr);
        end
        #1;
    endtask

    task automatic checkOutput(input string tag);
        logic [15:0] exp_top;
        exp_top = (q.size() != 0) ? q[q.size()-1] : 16'h0000;
        cmp({tag, ".rsp"}, 32'(rsp), 32'(q.size()));
        cmp({tag, ".r_out"}, 32'(r_out), 32'(exp_top));
        cmp({tag, ".empty"}, 32'(empty), 32'(q.size() == 0));
        cmp({tag, ".full"}, 32'(full), 32'(q.size() == 255));
        cmp({tag, ".ovf"}, 32'(ovf), 32'(m_ovf));
        cmp({tag, ".unf"}, 32'(unf), 32'(m_unf));
        cmp({tag, ".ill"}, 32'(ill), 32'(m_ill));
        cmp({tag, ".stall"}, 32'(stall), 32'(m_dumping));
        cmp({tag, ".dump_valid"}, 32'(dump_valid), 32'(m_dumping));
        cmp({tag, ".dump_idx"}, 32'(dump_idx), 32'(m_idx));
        cmp({tag, ".dump_last"}, 32'(dump_last), 32'(m_dumping && m_idx == 1));
        if (m_dumping) cmp({tag, ".dump_data"}, 32'(dump_data), 32'(q[m_idx-1]));
    endtask

    // Shorthand for a plain stack op with no dump activity.
    task automatic stackOp(input logic a_en, input logic [1:0] a_delta,
                           input logic [15:0] a_data, input logic a_clr);
        applyStimulus(a_en, a_delta, a_data, a_clr, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        logic [1:0] d;
        logic       dreq;
        int         pat[4];
        rst_n = 1'b0; en = 1'b0; rs_delta = 2'b00; push_data = '0;
        err_clr = 1'b0; dump_req = 1'b0; dump_ready = 1'b0;

        applyStimulus(1'b0, 2'b00, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 2'b00, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("reset");

        stackOp(1'b1, 2'b01, 16'h1234, 1'b0);
        checkOutput("push1");
        stackOp(1'b1, 2'b01, 16'hBEEF, 1'b0);
        checkOutput("push2");
        cmp("push2_rout_const", 32'(r_out), 32'h0000BEEF);
        stackOp(1'b1, 2'b11, 16'h0, 1'b0);
        checkOutput("pop1");
        cmp("pop1_rout_const", 32'(r_out), 32'h00001234);
        stackOp(1'b1, 2'b11, 16'h0, 1'b0);
        checkOutput("pop2");

        stackOp(1'b1, 2'b11, 16'h0, 1'b0);
        checkOutput("underflow");
        cmp("underflow_const", 32'(unf), 32'h1);
        stackOp(1'b1, 2'b01, 16'h5555, 1'b0);
        checkOutput("unf_sticky");
        stackOp(1'b0, 2'b00, 16'h0, 1'b1);
        checkOutput("unf_clear");
        stackOp(1'b1, 2'b11, 16'h0, 1'b0);
        stackOp(1'b1, 2'b11, 16'h0, 1'b1);
        checkOutput("unf_set_wins");
        stackOp(1'b0, 2'b00, 16'h0, 1'b1);

        for (int i = 1; i <= 255; i++) begin
            stackOp(1'b1, 2'b01, 16'(i), 1'b0);
            checkOutput($sformatf("fill%0d", i));
        end
        stackOp(1'b1, 2'b01, 16'hAAAA, 1'b0);
        checkOutput("overflow");
        cmp("overflow_rout_const", 32'(r_out), 32'h000000FF);
        stackOp(1'b1, 2'b11, 16'h0, 1'b0);
        checkOutput("pop_after_ovf");

        applyStimulus(1'b0, 2'b00, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("reset2");
        stackOp(1'b1, 2'b01, 16'h0A0A, 1'b0);
        stackOp(1'b1, 2'b01, 16'h0B0B, 1'b0);
        stackOp(1'b1, 2'b01, 16'h0C0C, 1'b0);
        stackOp(1'b1, 2'b10, 16'hFFFF, 1'b0);
        checkOutput("reserved_en");
        stackOp(1'b0, 2'b00, 16'h0, 1'b1);
        stackOp(1'b0, 2'b10, 16'hFFFF, 1'b0);
        checkOutput("reserved_no_en");

        applyStimulus(1'b0, 2'b00, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        stackOp(1'b1, 2'b01, 16'h0011, 1'b0);
        stackOp(1'b1, 2'b01, 16'h0022, 1'b0);
        stackOp(1'b1, 2'b01, 16'h0033, 1'b0);
        applyStimulus(1'b0, 2'b00, 16'h0, 1'b0, 1'b1, 1'b0, 1'b1);
        checkOutput("dump_start");
        pat = '{1, 0, 1, 1};
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 2'b01, 16'h9999, 1'b0, 1'b0, 1'(pat[i]), 1'b1);
            checkOutput($sformatf("dump_beat%0d", i));
        end
        cmp("dump_done_rsp_const", 32'(rsp), 32'h3);
        cmp("dump_done_rout_const", 32'(r_out), 32'h33);

        applyStimulus(1'b0, 2'b00, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 2'b00, 16'h0, 1'b0, 1'b1, 1'b1, 1'b1);
        checkOutput("dump_empty");

        stackOp(1'b1, 2'b01, 16'h0101, 1'b0);
        stackOp(1'b1, 2'b01, 16'h0202, 1'b0);
        applyStimulus(1'b0, 2'b00, 16'h0, 1'b0, 1'b1, 1'b0, 1'b1);
        applyStimulus(1'b0, 2'b00, 16'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("pre_reset_dump");
        applyStimulus(1'b0, 2'b00, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("reset_mid_dump");

        for (int i = 0; i < 600; i++) begin
            case ($urandom % 8)
                0, 1, 2: d = 2'b01;
                3, 4, 5: d = 2'b11;
                6:       d = 2'b10;
                default: d = 2'b00;
            endcase
            dreq = ($urandom % 16) == 0;
            applyStimulus(dreq ? 1'b0 : 1'(($urandom % 4) != 0), d, 16'($urandom),
                          1'(($urandom % 8) == 0), dreq, 1'($urandom % 2), 1'b1);
            checkOutput($sformatf("rand%0d", i));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/return_stack_reader.md
Name: return_stack_reader

Overview:
Owns the J1 return stack's storage and pointer, and provides the read side that the CPU needs: a registered top-of-stack value, push/pop pointer arithmetic, and error flags.
It also contains a debug dump engine that streams every live entry, top first, over a valid/ready handshake.
It sits between the J1 decode stage, which supplies the rstack delta field and push data, and the debug/trace port.

Parameters:
DW, 16, data width of a stack entry
AW, 8, pointer width; DEPTH = 2**AW words, usable capacity DEPTH-1

Ports:
clk  in  1  clock
rst_n  in  1  reset, synchronous, active-low
en  in  1  CPU pipeline advance; stack op applied only when en=1
rs_delta  in  2  00 nop, 01 push, 11 pop, 10 reserved
push_data  in  DW  value written on push (return address or T)
r_out  out  DW  registered top-of-stack (R); 0 when empty
rsp  out  AW  stack pointer = live entry count
empty  out  1  rsp==0
full  out  1  rsp==DEPTH-1
ovf  out  1  sticky: push attempted while full
unf  out  1  sticky: pop attempted while empty
ill  out  1  sticky: reserved delta 10 seen with en=1
err_clr  in  1  clears ovf/unf/ill
stall  out  1  high while the dump engine is busy; the CPU must hold en=0
dump_req  in  1  start dump (level, sampled in IDLE)
dump_valid  out  1  dump beat valid
dump_ready  in  1  sink accepts beat
dump_data  out  DW  entry at dump_idx
dump_idx  out  AW  index of current beat
dump_last  out  1  current beat is index 1

Behaviour:
- Reset: rsp=0, r_out=0, ovf=unf=ill=0, FSM=IDLE, dump_valid=0, dump_idx=0, dump_last=0, stall=0. All storage is cleared to 0.
- Storage: mem[1..DEPTH-1] holds entries. mem[0] is never written. r_out always equals mem[rsp] one cycle after any change.
- Ops apply only when en=1 and FSM=IDLE. With en=0 nothing changes.
- Push, not full: mem[rsp+1]<=push_data; rsp<=rsp+1; r_out<=push_data. Latency 1 cycle.
- Push, full: no write, rsp unchanged, ovf<=1.
- Pop, not empty: rsp<=rsp-1; r_out<=mem[rsp-1] (0 when rsp-1==0).
- Pop, empty: rsp stays 0, r_out stays 0, unf<=1.
- Delta 10: no state change; ill<=1.
- Pointer never wraps: 0 and DEPTH-1 saturate as above.
- Flags: err_clr=1 clears all sticky flags. If a set condition occurs in the same cycle as err_clr, set wins.
- Dump FSM states: IDLE, SEND.
  - IDLE -> SEND when dump_req=1 and rsp!=0; dump_idx<=rsp; stall<=1.
  - dump_req with rsp==0 is ignored and the FSM stays IDLE.
  - SEND: dump_valid=1, dump_data=mem[dump_idx], dump_last=(dump_idx==1).
  - Beat transfers when valid&&ready. If last: -> IDLE, valid<=0, stall<=0. Otherwise dump_idx<=dump_idx-1.
  - dump_data and dump_idx are held stable while valid&&!ready.
  - Stack contents, rsp, and r_out are unchanged by a dump. en/rs_delta are ignored during SEND; ops presented there are dropped and no flags are set.
- Reset mid-dump: FSM to IDLE, dump_valid drops the next edge, stack cleared.
- Widths: rsp±1 is computed in AW bits; the saturation checks precede the update.

Decomposition:
- Shared package rstack_pkg holds:
  - RS_NOP=2'b00, RS_PUSH=2'b01, RS_POP=2'b11, RS_RSV=2'b10
  - default DW/AW
  - the dump state enum {IDLE, SEND}
- One sub-module, rstack_dump_fsm: the valid/ready dump sequencer. It takes rsp and mem read data, and outputs dump_idx, valid, last, and stall.
- Storage, pointer, and flags stay in the top module.

Test Plan:
- Reset, then push 0x1234 then 0xBEEF with en=1 -> rsp=2, r_out=0xBEEF. Pop -> rsp=1, r_out=0x1234. Pop -> rsp=0, r_out=0, empty=1.
- Pop at rsp=0 -> unf=1, rsp=0. Push with err_clr=0 -> unf stays 1. err_clr pulse -> unf=0. err_clr concurrent with a second empty pop -> unf=1.
- Push 255 values 1..255 -> full=1, r_out=255. A 256th push (0xAAAA) -> ovf=1, rsp=255, r_out=255, mem unchanged.
- rs_delta=10 with en=1 at rsp=3 -> ill=1, rsp=3, r_out unchanged. Same delta with en=0 -> ill stays 0.
- Push 0x11, 0x22, 0x33, then dump_req with dump_ready toggling 1,0,1,1 -> beats (idx3,0x33), (idx2,0x22), (idx1,0x11,last=1), data held during the ready=0 cycle, stall high throughout. Afterwards rsp=3, r_out=0x33. A push offered during the dump is dropped.
- dump_req at rsp=0 -> no dump_valid, stall=0. Assert rst_n=0 during a dump -> next edge valid=0, rsp=0, FSM IDLE.
